// File: rtl/fast_conf_parser_if.sv
// fast_conf_parser_if: host flit input, TCM port, CPU select, response and forward ports of the FAST config parser.
interface fast_conf_parser_if #(parameter int ADDR_W = 12);
   logic              data_in_valid;
   logic [133:0]      data_in;
   logic              mem_wren;
   logic              mem_rden;
   logic [ADDR_W-1:0] mem_addr;
   logic [31:0]       mem_wdata;
   logic [31:0]       mem_rdata;
   logic              cpu_sel;
   logic              data_out_valid;
   logic [133:0]      data_out;
   logic              pkt_out_valid;
   logic [133:0]      pkt_out;
   logic [15:0]       err_cnt;
   modport slave (
      input  data_in_valid, data_in, mem_rdata,
      output mem_wren, mem_rden, mem_addr, mem_wdata, cpu_sel,
             data_out_valid, data_out, pkt_out_valid, pkt_out, err_cnt
   );
   modport master (
      output data_in_valid, data_in, mem_rdata,
      input  mem_wren, mem_rden, mem_addr, mem_wdata, cpu_sel,
             data_out_valid, data_out, pkt_out_valid, pkt_out, err_cnt
   );
endinterface

// File: rtl/fast_conf_parser.sv
// fast_conf_parser: decodes FAST control packets into TCM accesses, CPU select and responses; forwards the rest.
// Define FAST_CONF_WR_ACK_EN to queue an ack frame at the end of every 0x9003 write packet.
module fast_conf_parser #(parameter int ADDR_W = 12) (
   input logic clk,
   input logic resetn,
   fast_conf_parser_if.slave bus
);
   typedef enum logic [2:0] {IDLE, HDR, SEL, STAT, WR, RD, FWD, DROP} state_t;
   state_t state, nxt, hdr_nxt;
   logic v, is_start, is_end, is_mid, known, hdr, hdr_sel, fwd_start;
   logic wr_flit, bad, rd_flit, trig, busy, drop;
   logic [15:0] ptype, wr_cnt, rtype;
   logic [1:0] err_inc, ph;
   logic [16:0] err_sum;
   logic [133:0] s1;
   logic s1_v, rd_got, rd_cap;
   logic [31:0] rdata_q, rd_addr, rd_val, resp_lo;
   logic [127:0] last;
`ifdef FAST_CONF_WR_ACK_EN
   logic [15:0] pkt_wr, pkt_wr_n;
   assign pkt_wr_n = pkt_wr + {15'b0, wr_flit && !bad};
`endif
   always_comb begin
      v = bus.data_in_valid;
      is_start = bus.data_in[133:132] == 2'b01;
      is_end = bus.data_in[133:132] == 2'b10;
      is_mid = !is_start && !is_end;
      ptype = bus.data_in[31:16];
      known = ptype == 16'h9001 || ptype == 16'h9002 || ptype == 16'h9003 || ptype == 16'h9004;
      hdr_nxt = ptype == 16'h9001 ? SEL : ptype == 16'h9002 ? STAT : ptype == 16'h9003 ? WR :
                ptype == 16'h9004 ? RD : bus.cpu_sel ? FWD : DROP;
      nxt = !v ? state : is_start ? HDR : is_end ? IDLE : state == HDR ? hdr_nxt : state;
      hdr = v && state == HDR && !is_start;
      hdr_sel = hdr && ptype == 16'h9001;
      fwd_start = hdr && !known && bus.cpu_sel;
      wr_flit = v && state == WR && !is_start;
      bad = |bus.data_in[47:16+ADDR_W];
      rd_flit = v && state == RD && !is_start && !rd_got;
`ifdef FAST_CONF_WR_ACK_EN
      trig = v && is_end && (state == STAT || state == RD || state == WR);
`else
      trig = v && is_end && (state == STAT || state == RD);
`endif
      busy = bus.data_out_valid || ph != 2'd0;
      drop = trig && busy;
      err_inc = {1'b0, v && state == IDLE && is_mid} + {1'b0, wr_flit && bad} + {1'b0, drop};
      err_sum = {1'b0, bus.err_cnt} + {15'b0, err_inc};
      // read data arrives in the same cycle the last response flit is built
      rd_val = rd_cap ? bus.mem_rdata : rdata_q;
      last = {48'b0, rtype == 16'h9004 ? rd_val : 32'b0, rtype == 16'h9004 ? rd_addr : resp_lo, 16'b0};
   end
   always_ff @(posedge clk or negedge resetn)
      if (!resetn) state <= IDLE;
      else state <= nxt;
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         s1 <= '0;
         s1_v <= 1'b0;
         bus.pkt_out_valid <= 1'b0;
         bus.pkt_out <= '0;
         bus.mem_wren <= 1'b0;
         bus.mem_rden <= 1'b0;
         bus.mem_addr <= '0;
         bus.mem_wdata <= '0;
         bus.cpu_sel <= 1'b0;
         bus.err_cnt <= '0;
         bus.data_out_valid <= 1'b0;
         bus.data_out <= '0;
         wr_cnt <= '0;
         rd_got <= 1'b0;
         rd_addr <= '0;
         rd_cap <= 1'b0;
         rdata_q <= '0;
         ph <= '0;
         rtype <= '0;
         resp_lo <= '0;
`ifdef FAST_CONF_WR_ACK_EN
         pkt_wr <= '0;
`endif
      end else begin
         // s1 holds the last accepted flit; the start flit waits there until flit#1 reveals the type
         if (v) s1 <= bus.data_in;
         s1_v <= v && (fwd_start || (state == FWD && !is_start));
         bus.pkt_out_valid <= fwd_start || s1_v;
         if (fwd_start || s1_v) bus.pkt_out <= s1;
         bus.mem_wren <= wr_flit && !bad;
         bus.mem_rden <= rd_flit;
         if (wr_flit || rd_flit) bus.mem_addr <= bus.data_in[16 +: ADDR_W];
         if (wr_flit) bus.mem_wdata <= bus.data_in[79:48];
         wr_cnt <= wr_cnt + {15'b0, wr_flit && !bad};
         rd_got <= (v && is_start) ? 1'b0 : rd_got || rd_flit;
         if (rd_flit) rd_addr <= bus.data_in[47:16];
         rd_cap <= bus.mem_rden;
         if (rd_cap) rdata_q <= bus.mem_rdata;
         if (hdr_sel) bus.cpu_sel <= bus.data_in[0];
         bus.err_cnt <= err_sum[16] ? 16'hFFFF : err_sum[15:0];
`ifdef FAST_CONF_WR_ACK_EN
         pkt_wr <= (v && is_start) ? 16'b0 : pkt_wr_n;
`endif
         if (ph == 2'd1) begin
            bus.data_out <= {2'b11, 4'b0, 96'b0, rtype, 16'b0};
            ph <= 2'd2;
         end else if (ph == 2'd2) begin
            bus.data_out <= {2'b10, 4'b0, last};
            ph <= 2'd0;
         end else if (trig && !busy) begin
            bus.data_out <= {2'b01, 132'b0};
            ph <= 2'd1;
            rtype <= state == STAT ? 16'h9002 : state == RD ? 16'h9004 : 16'h9003;
`ifdef FAST_CONF_WR_ACK_EN
            resp_lo <= state == WR ? {16'b0, pkt_wr_n} : {15'b0, bus.cpu_sel, wr_cnt};
`else
            resp_lo <= {15'b0, bus.cpu_sel, wr_cnt};
`endif
         end
         bus.data_out_valid <= ph != 2'd0 || (trig && !busy);
      end
   end
endmodule

// File: tb/tb_fast_conf_parser.sv
// tb_fast_conf_parser: directed checks of select, write, read, status, forwarding, drop and error counting.
module tb_fast_conf_parser;
   logic clk = 1'b0;
   logic resetn = 1'b0;
   int errors = 0;
   int checks = 0;
   logic [31:0] mem [0:4095];
   logic [133:0] pk [5];
   logic seen;
   always #5 clk = ~clk;
   fast_conf_parser_if #(.ADDR_W(12)) bus ();
   fast_conf_parser #(.ADDR_W(12)) dut (.clk(clk), .resetn(resetn), .bus(bus));
   always @(posedge clk) begin
      if (bus.mem_wren) mem[bus.mem_addr] <= bus.mem_wdata;
      if (bus.mem_rden) bus.mem_rdata <= mem[bus.mem_addr];
   end
   function automatic logic [133:0] fl(input logic [1:0] tg, input logic [127:0] d);
      return {tg, 4'hF, d};
   endfunction
   function automatic logic [127:0] hd(input logic [15:0] t, input logic [15:0] lo);
      return {96'b0, t, lo};
   endfunction
   function automatic logic [127:0] ww(input logic [31:0] a, input logic [31:0] d);
      return {48'b0, d, a, 16'b0};
   endfunction
   task automatic tick(input logic v, input logic [133:0] d);
      bus.data_in_valid = v;
      bus.data_in = d;
      @(posedge clk);
      @(negedge clk);
   endtask
   task automatic idle();
      tick(1'b0, '0);
   endtask
   task automatic chk(input string tag, input logic [139:0] obs, input logic [139:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask
   initial begin
      bus.data_in_valid = 1'b0;
      bus.data_in = '0;
      repeat (2) @(negedge clk);
      chk("rst_ctl", {bus.mem_wren, bus.mem_rden, bus.data_out_valid, bus.pkt_out_valid, bus.cpu_sel}, 0);
      chk("rst_err", bus.err_cnt, 0);
      chk("rst_dout", bus.data_out, 0);
      chk("rst_pout", bus.pkt_out, 0);
      chk("rst_mem", {bus.mem_addr, bus.mem_wdata}, 0);
      resetn = 1'b1;
      tick(1'b1, fl(2'b01, 128'h0));
      chk("sel_pre", bus.cpu_sel, 0);
      tick(1'b1, fl(2'b11, hd(16'h9001, 16'h0001)));
      chk("sel_set", bus.cpu_sel, 1);
      tick(1'b1, fl(2'b10, 128'h0));
      idle();
      chk("sel_quiet", {bus.mem_wren, bus.mem_rden, bus.data_out_valid, bus.pkt_out_valid, bus.err_cnt}, 0);
      tick(1'b1, fl(2'b01, 128'h0));
      tick(1'b1, fl(2'b11, hd(16'h9003, 16'h0)));
      for (int i = 0; i < 4; i++) begin
         if (i == 2) begin
            idle();
            chk("wr_gap", bus.mem_wren, 0);
         end
         tick(1'b1, fl(i == 3 ? 2'b10 : 2'b11, ww(32'(i), 32'hA0 + 32'(i))));
         chk($sformatf("wr%0d", i), {bus.mem_wren, bus.mem_addr, bus.mem_wdata}, {1'b1, 12'(i), 32'hA0 + 32'(i)});
      end
      idle();
      chk("wr_end", bus.mem_wren, 0);
      repeat (3) idle();
      tick(1'b1, fl(2'b01, 128'h0));
      tick(1'b1, fl(2'b11, hd(16'h9003, 16'h0)));
      tick(1'b1, fl(2'b10, ww(32'h1000, 32'h55)));
      chk("bad_wren", bus.mem_wren, 0);
      chk("bad_err", bus.err_cnt, 1);
      repeat (4) idle();
      tick(1'b1, fl(2'b01, 128'h0));
      tick(1'b1, fl(2'b11, hd(16'h9003, 16'h0)));
      tick(1'b1, fl(2'b10, ww(32'd128, 32'hDEADBEEF)));
      chk("pre_wr", {bus.mem_wren, bus.mem_addr, bus.mem_wdata}, {1'b1, 12'd128, 32'hDEADBEEF});
      repeat (4) idle();
      tick(1'b1, fl(2'b01, 128'h0));
      tick(1'b1, fl(2'b11, hd(16'h9004, 16'h0)));
      tick(1'b1, fl(2'b10, ww(32'd128, 32'h0)));
      chk("rd_en", {bus.mem_rden, bus.mem_addr}, {1'b1, 12'd128});
      chk("rd_f0", {bus.data_out_valid, bus.data_out}, {1'b1, 2'b01, 132'b0});
      idle();
      chk("rd_f1", {bus.data_out_valid, bus.data_out}, {1'b1, 2'b11, 4'b0, 96'b0, 16'h9004, 16'b0});
      idle();
      chk("rd_f2", {bus.data_out_valid, bus.data_out}, {1'b1, 2'b10, 4'b0, 48'b0, 32'hDEADBEEF, 32'd128, 16'b0});
      idle();
      chk("rd_done", bus.data_out_valid, 0);
      pk[0] = fl(2'b01, 128'h0123_4567_89AB_CDEF_0011_2233_4455_6677);
      pk[1] = fl(2'b11, {96'hAAAA_5555_AAAA_5555_AAAA_5555, 16'h9010, 16'h0BAD});
      pk[2] = {2'b00, 4'h3, 128'hFEDC_BA98_7654_3210_FFFF_0000_1234_5678};
      pk[3] = fl(2'b11, 128'h1357_9BDF_2468_ACE0_1357_9BDF_2468_ACE0);
      pk[4] = {2'b10, 4'h5, 128'h0000_0000_0000_0000_0000_00C0_FFEE_0001};
      for (int k = 0; k < 5; k++) begin
         tick(1'b1, pk[k]);
         if (k == 0) chk("fwd_v0", bus.pkt_out_valid, 0);
         else begin
            chk($sformatf("fwd_v%0d", k), bus.pkt_out_valid, 1);
            chk($sformatf("fwd_d%0d", k), bus.pkt_out, pk[k-1]);
         end
      end
      idle();
      chk("fwd_last", {bus.pkt_out_valid, bus.pkt_out}, {1'b1, pk[4]});
      idle();
      chk("fwd_done", bus.pkt_out_valid, 0);
      tick(1'b1, fl(2'b01, 128'h0));
      tick(1'b1, fl(2'b11, hd(16'h9001, 16'h0000)));
      tick(1'b1, fl(2'b10, 128'h0));
      chk("sel_clr", bus.cpu_sel, 0);
      seen = 1'b0;
      for (int k = 0; k < 5; k++) begin
         tick(1'b1, pk[k]);
         seen |= bus.pkt_out_valid;
      end
      repeat (2) begin
         idle();
         seen |= bus.pkt_out_valid;
      end
      chk("drop_none", seen, 0);
      tick(1'b1, fl(2'b01, 128'h0));
      tick(1'b1, fl(2'b11, hd(16'h9002, 16'h0)));
      tick(1'b1, fl(2'b10, 128'h0));
      chk("st_f0", {bus.data_out_valid, bus.data_out}, {1'b1, 2'b01, 132'b0});
      tick(1'b1, fl(2'b01, 128'h0));
      chk("st_f1", {bus.data_out_valid, bus.data_out}, {1'b1, 2'b11, 4'b0, 96'b0, 16'h9002, 16'b0});
      tick(1'b1, fl(2'b11, hd(16'h9002, 16'h0)));
      chk("st_f2", {bus.data_out_valid, bus.data_out}, {1'b1, 2'b10, 4'b0, 80'b0, 15'b0, 1'b0, 16'd5, 16'b0});
      tick(1'b1, fl(2'b10, 128'h0));
      chk("st_drop_v", bus.data_out_valid, 0);
      chk("st_drop_err", bus.err_cnt, 2);
      repeat (2) idle();
      chk("st_quiet", bus.data_out_valid, 0);
      tick(1'b1, fl(2'b11, 128'h0));
      chk("orphan_err", bus.err_cnt, 3);
      tick(1'b1, fl(2'b01, 128'h0));
      tick(1'b1, fl(2'b11, hd(16'h9003, 16'h0)));
      tick(1'b1, fl(2'b11, ww(32'd5, 32'h77)));
      chk("abort_pre", {bus.mem_wren, bus.mem_addr, bus.mem_wdata}, {1'b1, 12'd5, 32'h77});
      tick(1'b1, fl(2'b01, 128'h0));
      chk("abort_start", bus.mem_wren, 0);
      tick(1'b1, fl(2'b11, ww(32'd6, 32'h88)));
      chk("abort_nowr", bus.mem_wren, 0);
      chk("abort_err", bus.err_cnt, 3);
      tick(1'b1, fl(2'b10, 128'h0));
      idle();
      tick(1'b1, fl(2'b01, 128'h0));
      tick(1'b1, fl(2'b11, hd(16'h9001, 16'h0001)));
      chk("rst2_sel", bus.cpu_sel, 1);
      #2 resetn = 1'b0;
      #1 chk("rst2_async", {bus.cpu_sel, bus.err_cnt}, 0);
      @(negedge clk);
      resetn = 1'b1;
      tick(1'b1, fl(2'b11, ww(32'd7, 32'h99)));
      chk("rst2_orphan", {bus.mem_wren, bus.err_cnt}, {1'b0, 16'd1});
      idle();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
